mem_access_unit: RTL and testbench

//  Initiator side of the word-wide RAM port: turns CPU load/store requests (byte/half/word,
//  any alignment check) into ram read_enable/write_enable/address/data_in cycles. RAM is

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, negedge-acting RAM. Sub-word stores are done as
// read-modify-write. Only one request is in flight at a time.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS   = 18,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {
    StIdle, StRd, StWr, StRmwRd, StRmwWr, StResp, StErrResp
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        re_q, re_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, ram_wdata_q, ram_wdata_d;
  logic        resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext, merged;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (CHECK_RANGE && ((req_addr >> ADDR_BITS) != 32'd0)) req_err = 1'b1;
  end

  // Lane extraction and merge both work on the word RAM returned during this access.
  always_comb begin
    rd_byte = ram_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = ram_rdata[7:0];
      2'd1: rd_byte = ram_rdata[15:8];
      2'd2: rd_byte = ram_rdata[23:16];
      2'd3: rd_byte = ram_rdata[31:24];
      default: rd_byte = ram_rdata[7:0];
    endcase
    rd_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_ext = ram_rdata;
    endcase
    merged = ram_rdata;
    if (size_q == 2'b00) begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_rdata;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    ram_wdata_d  = ram_wdata_q;
    re_d         = 1'b0;
    we_d         = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = 32'd0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          addr_d  = {req_addr[31:2], 2'b00};
          if (req_err) begin
            state_d      = StErrResp;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (!req_write) begin
            state_d = StRd;
            re_d    = 1'b1;
          end else if (req_size == 2'b10) begin
            state_d     = StWr;
            we_d        = 1'b1;
            ram_wdata_d = req_wdata;
          end else begin
            state_d = StRmwRd;
            re_d    = 1'b1;
          end
        end
      end
      StRd: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end
      StWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
      end
      StRmwRd: begin
        state_d     = StRmwWr;
        we_d        = 1'b1;
        ram_wdata_d = merged;
      end
      StRmwWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'd0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      ram_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      re_q         <= re_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready        = (state_q == StIdle);
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign ram_read_enable  = re_q;
  assign ram_write_enable = we_q;
  assign ram_address      = addr_q;
  assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-acting word RAM model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_error, ram_read_enable, ram_write_enable;
  logic [31:0] resp_rdata, ram_address, ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_BITS(18), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_write_enable) mem[ram_address[11:2]] <= ram_wdata;
    if (ram_read_enable) ram_rdata <= mem[ram_address[11:2]];
    else                 ram_rdata <= 32'hzzzz_zzzz;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results of the most recent request
  logic [31:0] r_data, r_addr;
  logic        r_err, r_overlap;
  int          r_lat, r_re_idx, r_we_idx;

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 0; r_re_idx = -1; r_we_idx = -1; r_overlap = 1'b0; r_addr = 32'hFFFF_FFFF;
    while (!resp_valid && r_lat < 10) begin
      if (ram_read_enable && r_re_idx < 0) r_re_idx = r_lat;
      if (ram_write_enable && r_we_idx < 0) r_we_idx = r_lat;
      if (ram_read_enable && ram_write_enable) r_overlap = 1'b1;
      if (ram_read_enable || ram_write_enable) r_addr = ram_address;
      @(posedge clk); #1;
      r_lat++;
    end
    if (ram_read_enable || ram_write_enable) r_overlap = 1'b1;
    r_data = resp_rdata;
    r_err  = resp_error;
  endtask

  initial begin
    logic saw_resp, saw_we;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_re", {31'd0, ram_read_enable}, 32'd0);
    check("rst_we", {31'd0, ram_write_enable}, 32'd0);
    check("rst_addr", ram_address, 32'd0);

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    check("sw_lat", r_lat, 1);
    check("sw_err", {31'd0, r_err}, 32'd0);
    check("sw_rdata", r_data, 32'd0);
    check("sw_we_idx", r_we_idx, 0);
    check("sw_re_idx", r_re_idx, -1);
    check("sw_mem", mem[10'h40], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    check("lw_lat", r_lat, 1);
    check("lw_rdata", r_data, 32'hDEADBEEF);
    check("lw_addr", r_addr, 32'h100);

    // Byte store via read-modify-write
    mem[10'h40] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF7F);
    check("sb_lat", r_lat, 2);
    check("sb_re_idx", r_re_idx, 0);
    check("sb_we_idx", r_we_idx, 1);
    check("sb_overlap", {31'd0, r_overlap}, 32'd0);
    check("sb_addr", r_addr, 32'h100);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    check("sb_readback", r_data, 32'h11227F44);

    // Byte loads, signed and unsigned
    mem[10'h40] = 32'h80123456;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    check("lb_signed", r_data, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
    check("lbu", r_data, 32'h00000080);
    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'd0);
    check("lb_lane1", r_data, 32'h00000034);

    // Half load, half store
    mem[10'h40] = 32'hBEEF0000;
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'd0);
    check("lh_signed", r_data, 32'hFFFFBEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0);
    check("lhu", r_data, 32'h0000BEEF);
    do_req(1'b1, 2'b01, 1'b0, 32'h100, 32'hA5A51234);
    check("sh_lat", r_lat, 2);
    check("sh_mem", mem[10'h40], 32'hBEEF1234);

    // Error responses
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'd0);
    check("mis_half_err", {31'd0, r_err}, 32'd1);
    check("mis_half_lat", r_lat, 0);
    check("mis_half_rdata", r_data, 32'd0);
    check("mis_half_en", {r_re_idx, r_we_idx}, {-32'sd1, -32'sd1});
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'd0);
    check("mis_word_err", {31'd0, r_err}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'd0);
    check("range_err", {31'd0, r_err}, 32'd1);
    check("range_en", {r_re_idx, r_we_idx}, {-32'sd1, -32'sd1});
    do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678);
    check("size11_err", {31'd0, r_err}, 32'd1);
    check("size11_mem", mem[10'h40], 32'hBEEF1234);
    do_req(1'b0, 2'b10, 1'b0, 32'h0003_FFFC, 32'd0);
    check("top_in_range", {31'd0, r_err}, 32'd0);

    // Reset during RMW_RD aborts the store
    mem[10'h40] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h100;
    req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_rd_re", {31'd0, ram_read_enable}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    saw_resp = 1'b0; saw_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) saw_resp = 1'b1;
      if (ram_write_enable) saw_we = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_no_resp", {31'd0, saw_resp}, 32'd0);
    check("rst_mid_no_we", {31'd0, saw_we}, 32'd0);
    check("rst_mid_mem", mem[10'h40], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
